// File: rtl/operand2_pkg.sv
// Shared types for the operand-2 shifter pipeline: modes, shift kinds, decoded request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand2_pkg;

   // Widest supported datapath; the decoded request carries rm at this width.
   localparam int XLEN_MAX = 64;

   // LSB of the 4-bit rotate field in the immediate form.
   localparam int ROT_FIELD_LSB = 8;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_kind_e;

   typedef enum logic [1:0] {
      OP_MEM     = 2'b00,
      OP_IMM_ROT = 2'b01,
      OP_IMM_SH  = 2'b10,
      OP_REG_SH  = 2'b11
   } op_mode_e;

   // Every mode is normalised onto register-shift semantics (amt 0..255) plus RRX,
   // so the shifter core only has to implement one rule set.
   typedef struct packed {
      op_mode_e              mode;
      shift_kind_e           kind;
      logic [7:0]            amt;
      logic                  is_rrx;
      logic [XLEN_MAX-1:0]   rm;
      logic                  carry_in;
   } dec_req_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational ARM barrel shifter: register-shift rules for amt 0..255, plus RRX.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module barrel_shift_core
   import operand2_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  shift_kind_e       i_kind,
   input  logic [7:0]        i_amt,
   input  logic              i_is_rrx,
   input  logic [XLEN-1:0]   i_rm,
   input  logic              i_carry_in,
   output logic [XLEN-1:0]   o_val2,
   output logic              o_carry
);

   localparam int         SHW      = $clog2(XLEN);
   localparam logic [7:0] AMT_XLEN = 8'(XLEN);

   logic [SHW-1:0]  w_r;
   logic [SHW-1:0]  w_r_m1;
   logic [SHW-1:0]  w_r_neg;
   logic [XLEN-1:0] w_lsl;
   logic [XLEN-1:0] w_lsr;
   logic [XLEN-1:0] w_asr;
   logic [XLEN-1:0] w_ror;
   logic [XLEN-1:0] w_lsl_m1;
   logic [XLEN-1:0] w_lsr_m1;
   logic            w_in_range;
   logic            w_at_xlen;
   logic            w_sign;

   // Low bits of the amount; equal to the full amount whenever it is below XLEN,
   // and equal to amt mod XLEN for rotates (XLEN is a power of two).
   assign w_r        = i_amt[SHW-1:0];
   assign w_r_m1     = w_r - SHW'(1);
   assign w_r_neg    = SHW'(0) - w_r;
   assign w_in_range = (i_amt < AMT_XLEN);
   assign w_at_xlen  = (i_amt == AMT_XLEN);
   assign w_sign     = i_rm[XLEN-1];

   // Shifted vectors; shifting by r-1 exposes the last bit shifted out at an end.
   assign w_lsl    = i_rm << w_r;
   assign w_lsr    = i_rm >> w_r;
   assign w_asr    = $signed(i_rm) >>> w_r;
   assign w_ror    = (i_rm >> w_r) | (i_rm << w_r_neg);
   assign w_lsl_m1 = i_rm << w_r_m1;
   assign w_lsr_m1 = i_rm >> w_r_m1;

   // Select result and carry-out by kind, with the out-of-range cases handled explicitly.
   always_comb begin
      o_val2  = i_rm;
      o_carry = i_carry_in;
      if (i_is_rrx) begin
         o_val2  = {i_carry_in, i_rm[XLEN-1:1]};
         o_carry = i_rm[0];
      end else if (i_amt != 8'd0) begin
         case (i_kind)
            SH_LSL: begin
               if (w_in_range) begin
                  o_val2  = w_lsl;
                  o_carry = w_lsl_m1[XLEN-1];
               end else begin
                  o_val2  = '0;
                  o_carry = w_at_xlen ? i_rm[0] : 1'b0;
               end
            end
            SH_LSR: begin
               if (w_in_range) begin
                  o_val2  = w_lsr;
                  o_carry = w_lsr_m1[0];
               end else begin
                  o_val2  = '0;
                  o_carry = w_at_xlen ? w_sign : 1'b0;
               end
            end
            SH_ASR: begin
               if (w_in_range) begin
                  o_val2  = w_asr;
                  o_carry = w_lsr_m1[0];
               end else begin
                  o_val2  = {XLEN{w_sign}};
                  o_carry = w_sign;
               end
            end
            default: begin
               if (w_r == SHW'(0)) begin
                  o_val2  = i_rm;
                  o_carry = w_sign;
               end else begin
                  o_val2  = w_ror;
                  o_carry = w_lsr_m1[0];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/operand2_shift_pipe.sv
// ARM shifter operand (Val2) and shifter carry-out, elastic pipeline with flush.
// Latency: PIPE_STAGES cycles (1 or 2) with no back-pressure; 1 result per cycle.
// Backpressure: valid/ready per stage; outputs hold while out_valid && !out_ready.
module operand2_shift_pipe
   import operand2_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 1,
   parameter int OFF_W       = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   rm_val,
   input  logic [7:0]        rs_val,
   input  logic              imm,
   input  logic              reg_shift,
   input  logic              mem_op,
   input  logic              carry_in,
   input  logic [11:0]       shift_operand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   val2,
   output logic              shifter_carry
);

   localparam logic [7:0] AMT_XLEN = 8'(XLEN);

   dec_req_t        w_dec;
   dec_req_t        w_core_req;
   logic            w_core_vld;
   logic            w_out_rdy;
   logic [XLEN-1:0] w_core_val2;
   logic            w_core_carry;
   logic            w_final_carry;

   logic            r_out_vld;
   logic [XLEN-1:0] r_val2;
   logic            r_carry;

   // Decode the instruction fields into one normalised shift request (priority mem > imm > reg > imm-shift).
   always_comb begin
      w_dec          = '0;
      w_dec.rm       = XLEN_MAX'(rm_val);
      w_dec.carry_in = carry_in;
      w_dec.kind     = shift_kind_e'(shift_operand[6:5]);
      if (mem_op) begin
         // Offset passes through as an unshifted operand.
         w_dec.mode = OP_MEM;
         w_dec.kind = SH_LSL;
         w_dec.amt  = 8'd0;
         w_dec.rm   = XLEN_MAX'(shift_operand[OFF_W-1:0]);
      end else if (imm) begin
         // Rotate-immediate behaves exactly like a register ROR by an even amount <= 30.
         w_dec.mode = OP_IMM_ROT;
         w_dec.kind = SH_ROR;
         w_dec.amt  = {3'b000, shift_operand[ROT_FIELD_LSB +: 4], 1'b0};
         w_dec.rm   = XLEN_MAX'(shift_operand[7:0]);
      end else if (reg_shift) begin
         w_dec.mode = OP_REG_SH;
         w_dec.amt  = rs_val;
      end else begin
         // Amount 0 is special: LSR/ASR mean "by XLEN", ROR means RRX.
         w_dec.mode = OP_IMM_SH;
         w_dec.amt  = {3'b000, shift_operand[11:7]};
         if (shift_operand[11:7] == 5'd0) begin
            case (w_dec.kind)
               SH_LSR, SH_ASR: w_dec.amt    = AMT_XLEN;
               SH_ROR:         w_dec.is_rrx = 1'b1;
               default:        w_dec.amt    = 8'd0;
            endcase
         end
      end
   end

   assign w_out_rdy = !r_out_vld || out_ready;

   generate
      if (PIPE_STAGES == 2) begin : g_two_stage
         logic     r_s0_vld;
         dec_req_t r_s0_req;

         // Stage 0 holds the decoded request; advances when the output stage can take it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s0_vld <= 1'b0;
               r_s0_req <= '0;
            end else begin
               if (flush) begin
                  r_s0_vld <= 1'b0;
               end else if (in_ready) begin
                  r_s0_vld <= in_valid;
               end
               if (in_ready && in_valid) begin
                  r_s0_req <= w_dec;
               end
            end
         end

         assign in_ready   = !r_s0_vld || w_out_rdy;
         assign w_core_req = r_s0_req;
         assign w_core_vld = r_s0_vld;
      end else begin : g_one_stage
         assign in_ready   = w_out_rdy;
         assign w_core_req = w_dec;
         assign w_core_vld = in_valid;
      end

      if (XLEN < XLEN_MAX) begin : g_narrow
         // Upper rm bits exist only for the 64-bit build.
         logic w_unused_rm_hi;
         assign w_unused_rm_hi = ^w_core_req.rm[XLEN_MAX-1:XLEN];
      end
   endgenerate

   barrel_shift_core #(
      .XLEN (XLEN)
   ) u_core (
      .i_kind     (w_core_req.kind),
      .i_amt      (w_core_req.amt),
      .i_is_rrx   (w_core_req.is_rrx),
      .i_rm       (w_core_req.rm[XLEN-1:0]),
      .i_carry_in (w_core_req.carry_in),
      .o_val2     (w_core_val2),
      .o_carry    (w_core_carry)
   );

   // Load/store offsets never alter C, whatever the shifter reports.
   assign w_final_carry = (w_core_req.mode == OP_MEM) ? w_core_req.carry_in : w_core_carry;

   // Output stage: captures the shift result; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_val2    <= '0;
         r_carry   <= 1'b0;
      end else begin
         if (flush) begin
            r_out_vld <= 1'b0;
         end else if (w_out_rdy) begin
            r_out_vld <= w_core_vld;
         end
         if (w_out_rdy && w_core_vld) begin
            r_val2  <= w_core_val2;
            r_carry <= w_final_carry;
         end
      end
   end

   assign out_valid     = r_out_vld;
   assign val2          = r_val2;
   assign shifter_carry = r_carry;

endmodule

// File: tb/tb_operand2_shift_pipe.sv
// Directed bench for operand2_shift_pipe (XLEN=32, two stages) with an in-order scoreboard.
module tb_operand2_shift_pipe;

   localparam int XLEN  = 32;
   localparam int PIPE  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   rm_val;
   logic [7:0]        rs_val;
   logic              imm;
   logic              reg_shift;
   logic              mem_op;
   logic              carry_in;
   logic [11:0]       shift_operand;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [XLEN-1:0]   val2;
   logic              shifter_carry;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          pops = 0;
   int          acc_cyc = 0;
   logic [32:0] exp_q[$];
   logic        tog_en = 1'b0;
   logic        rdy_force = 1'b1;
   logic [3:0]  pat = 4'b1001;
   logic        saw_full = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] held_v = '0;
   logic        held_c = 1'b0;

   operand2_shift_pipe #(
      .XLEN        (XLEN),
      .PIPE_STAGES (PIPE),
      .OFF_W       (12)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rm_val        (rm_val),
      .rs_val        (rs_val),
      .imm           (imm),
      .reg_shift     (reg_shift),
      .mem_op        (mem_op),
      .carry_in      (carry_in),
      .shift_operand (shift_operand),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .val2          (val2),
      .shifter_carry (shifter_carry)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer: either a fixed ready level or the 1,0,0,1 toggle pattern.
   always @(posedge clk) begin
      #1;
      out_ready = tog_en ? pat[cyc % 4] : rdy_force;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference written directly from the ARM shifter rules, XLEN=32.
   function automatic logic [32:0] ref_model(input logic [31:0] rm, input logic [7:0] rs,
                                             input logic im, input logic rsh, input logic mop,
                                             input logic cin, input logic [11:0] so);
      logic [31:0] v;
      logic        c;
      logic [63:0] dbl;
      int          n;
      v = rm;
      c = cin;
      if (mop) begin
         v = {20'd0, so};
         c = cin;
      end else if (im) begin
         n   = 2 * int'(so[11:8]);
         dbl = {24'd0, so[7:0], 24'd0, so[7:0]};
         dbl = dbl >> n;
         v   = dbl[31:0];
         c   = (n == 0) ? cin : v[31];
      end else if (!rsh) begin
         n = int'(so[11:7]);
         dbl = {rm, rm} >> n;
         case (so[6:5])
            2'b00: if (n == 0) begin v = rm; c = cin; end
                   else begin v = rm << n; c = rm[32 - n]; end
            2'b01: if (n == 0) begin v = '0; c = rm[31]; end
                   else begin v = rm >> n; c = rm[n - 1]; end
            2'b10: if (n == 0) begin v = {32{rm[31]}}; c = rm[31]; end
                   else begin v = $signed(rm) >>> n; c = rm[n - 1]; end
            default: if (n == 0) begin v = {cin, rm[31:1]}; c = rm[0]; end
                     else begin v = dbl[31:0]; c = rm[n - 1]; end
         endcase
      end else begin
         n = int'(rs);
         if (n != 0) begin
            case (so[6:5])
               2'b00: if (n < 32) begin v = rm << n; c = rm[32 - n]; end
                      else if (n == 32) begin v = '0; c = rm[0]; end
                      else begin v = '0; c = 1'b0; end
               2'b01: if (n < 32) begin v = rm >> n; c = rm[n - 1]; end
                      else if (n == 32) begin v = '0; c = rm[31]; end
                      else begin v = '0; c = 1'b0; end
               2'b10: if (n < 32) begin v = $signed(rm) >>> n; c = rm[n - 1]; end
                      else begin v = {32{rm[31]}}; c = rm[31]; end
               default: begin
                  n = n % 32;
                  dbl = {rm, rm} >> n;
                  if (n == 0) begin v = rm; c = rm[31]; end
                  else begin v = dbl[31:0]; c = rm[n - 1]; end
               end
            endcase
         end
      end
      return {c, v};
   endfunction

   // Scoreboard: pop and compare every accepted output; check stability across stalls.
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_val2", 64'(val2), 64'(held_v));
            chk("hold_carry", 64'(shifter_carry), 64'(held_c));
         end
         if (tog_en && in_valid && !in_ready) saw_full = 1'b1;
         if (out_valid && out_ready) begin
            chk("no_spurious_output", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("val2", 64'(val2), 64'(e[31:0]));
               chk("shifter_carry", 64'(shifter_carry), 64'(e[32]));
               pops++;
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         held_v     = val2;
         held_c     = shifter_carry;
      end
   end

   // Presents one request and waits (bounded) for acceptance; call at posedge+1.
   task automatic send(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                       input logic rsh, input logic mop, input logic cin,
                       input logic [11:0] so, input logic [31:0] ev, input logic ec);
      logic acc;
      rm_val = rm; rs_val = rs; imm = im; reg_shift = rsh; mem_op = mop;
      carry_in = cin; shift_operand = so; in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            exp_q.push_back({ec, ev});
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("accepted", 64'(acc), 64'd1);
   endtask

   task automatic send_model(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                             input logic rsh, input logic mop, input logic cin,
                             input logic [11:0] so);
      logic [32:0] r;
      r = ref_model(rm, rs, im, rsh, mop, cin, so);
      send(rm, rs, im, rsh, mop, cin, so, r[31:0], r[32]);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int   out_cyc;
      int   pops0;
      logic seen;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      rm_val = '0; rs_val = '0; imm = 1'b0; reg_shift = 1'b0; mem_op = 1'b0;
      carry_in = 1'b0; shift_operand = '0;

      // Reset state
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_val2", 64'(val2), 64'd0);
      chk("rst_carry", 64'(shifter_carry), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Rotate immediate with latency measurement
      send(32'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h4FF, 32'hFF000000, 1'b1);
      seen = 1'b0; out_cyc = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; out_cyc = cyc; end
      end
      chk("latency_seen", 64'(seen), 64'd1);
      chk("latency_cycles", 64'(out_cyc - acc_cyc), 64'(PIPE));
      @(posedge clk); #1;
      drain();

      // Directed vectors, one mode boundary each
      send(32'h80000001, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 32'h00000000, 1'b1); // LSR #0
      send(32'h00000003, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 12'h060, 32'h80000001, 1'b1); // RRX
      send(32'h00000001, 8'd32,  1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h00000000, 1'b1); // LSL by 32
      send(32'h00000001, 8'd33,  1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h00000000, 1'b0); // LSL by 33
      send(32'h00000001, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 12'h010, 32'h00000001, 1'b1); // reg amt 0
      send(32'h80000000, 8'd64,  1'b0, 1'b1, 1'b0, 1'b0, 12'h070, 32'h80000000, 1'b1); // ROR by 64
      send(32'h80000000, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0, 12'h050, 32'hFFFFFFFF, 1'b1); // ASR by 200
      send(32'h12345678, 8'd7,   1'b1, 1'b1, 1'b1, 1'b1, 12'hABC, 32'h00000ABC, 1'b1); // mem wins
      send(32'h0,        8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 12'h0FF, 32'h000000FF, 1'b1); // rot 0
      send(32'h0,        8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 12'h1FF, 32'hC000003F, 1'b1); // rot 2
      send(32'hF0000001, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 12'h200, 32'h00000010, 1'b1); // LSL #4
      send(32'h80000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 12'h040, 32'hFFFFFFFF, 1'b1); // ASR #0
      send(32'h80000000, 8'd32,  1'b0, 1'b1, 1'b0, 1'b0, 12'h030, 32'h00000000, 1'b1); // LSR by 32
      send(32'h80000010, 8'd4,   1'b0, 1'b1, 1'b0, 1'b0, 12'h050, 32'hF8000001, 1'b0); // ASR by 4
      send(32'h0000001F, 8'd36,  1'b0, 1'b1, 1'b0, 1'b0, 12'h070, 32'hF0000001, 1'b1); // ROR by 36
      drain();

      // Back-to-back stream under the 1,0,0,1 ready pattern
      pops0  = pops;
      tog_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_model($urandom, 8'($urandom_range(0, 255)), (i % 4) == 1, (i % 4) == 2,
                    (i % 4) == 0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
      end
      drain();
      tog_en = 1'b0;
      @(posedge clk); #1;
      chk("stream_count", 64'(pops - pops0), 64'd8);
      chk("stream_in_ready_low", 64'(saw_full), 64'd1);

      // Flush with two entries in flight; a request presented with flush is dropped
      rdy_force = 1'b0;
      @(posedge clk); #1;
      send(32'h1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h2, 1'b0);
      send(32'h2, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h4, 1'b0);
      @(negedge clk);
      chk("flush_pre_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; rm_val = 32'h5; shift_operand = 12'h0FF; imm = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_out_valid", 64'(out_valid), 64'd0);
      end
      rdy_force = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset mid-stream
      rdy_force = 1'b0;
      @(posedge clk); #1;
      send(32'hAAAA5555, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030, 32'h15554AAA, 1'b1);
      send(32'h0000FFFF, 8'd8, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h00FFFF00, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_val2", 64'(val2), 64'd0);
      chk("arst_carry", 64'(shifter_carry), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      rdy_force = 1'b1;
      @(posedge clk); #1;

      // Pipeline is usable again after reset
      send(32'h00000001, 8'd31, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h80000000, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand2_shift_pipe.md
Name: operand2_shift_pipe

Overview:
- Pipelined, parametrised successor of the EXE-stage operand-2 generator.
- Computes the ARM shifter operand (Val2) and the shifter carry-out for:
  - immediate rotate
  - immediate-amount shifts
  - register-specified shifts, including RRX
  - load/store offsets
- Registered valid/ready handshake with flush, so the shifter can be retimed out of the EXE critical path.
- Sits between the ID/EXE register and the ALU; shifter_carry feeds the ALU C-flag for logical ops with S=1.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PIPE_STAGES, 1, register depth; legal values 1 or 2.
- OFF_W, 12, width of the load/store immediate offset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight entries
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept this cycle
- rm_val  in  XLEN  Rm operand
- rs_val  in  8  Rs[7:0], the register shift amount
- imm  in  1  I bit
- reg_shift  in  1  instruction bit 4; register-specified shift when imm=0
- mem_op  in  1  load/store offset mode
- carry_in  in  1  current CPSR C
- shift_operand  in  12  instruction bits [11:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- val2  out  XLEN  shifter operand
- shifter_carry  out  1  shifter carry-out

Behaviour:
- Reset and flush
  - Async on rst_n low: every stage valid=0, val2=0, shifter_carry=0, out_valid=0. in_ready=1 after reset.
  - flush clears all stage valids on the next edge; data is don't-care. A request presented with flush in the same cycle is dropped.
- Handshake
  - Elastic pipeline; a transfer occurs when valid && ready.
  - in_ready = !stage0_valid || (downstream of stage0 advancing).
  - Latency is exactly PIPE_STAGES cycles with no back-pressure.
  - Full throughput: 1 result per cycle.
  - Outputs hold stable while out_valid && !out_ready.
- Mode priority: mem_op > imm > reg_shift > immediate shift.
- mem_op: val2 = zero-extended shift_operand[OFF_W-1:0]; carry = carry_in.
- imm (rotate immediate):
  - rot = 2*shift_operand[11:8]; val2 = ror(zext(imm8), rot) over XLEN.
  - carry = carry_in if rot==0, else val2[XLEN-1].
- Shift kind = shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Immediate shift (amount n = shift_operand[11:7]):
  - LSL #0: val2 = rm, carry = carry_in.
  - LSL n: carry = rm[XLEN-n].
  - LSR #0 encodes shift by XLEN: val2 = 0, carry = rm[XLEN-1].
  - ASR #0 encodes shift by XLEN: val2 = all rm[XLEN-1], carry = rm[XLEN-1].
  - ROR #0 is RRX: val2 = {carry_in, rm[XLEN-1:1]}, carry = rm[0].
  - LSR/ASR/ROR n>0: carry = rm[n-1].
- Register shift (amount a = rs_val, 0..255):
  - a==0 (any kind): val2 = rm, carry = carry_in.
  - LSL: a<XLEN normal; a==XLEN gives 0, carry rm[0]; a>XLEN gives 0, carry 0.
  - LSR: a<XLEN normal; a==XLEN gives 0, carry rm[XLEN-1]; a>XLEN gives 0, carry 0.
  - ASR: a>=XLEN gives all sign bits, carry = sign bit.
  - ROR: r = a mod XLEN; if r==0, val2 = rm and carry = rm[XLEN-1]; otherwise rotate by r, carry = rm[r-1].
- Stage split
  - PIPE_STAGES=1: one registered stage.
  - PIPE_STAGES=2: stage 0 registers the decoded kind, effective amount, special-case flags, rm and carry_in; stage 1 registers the shift result.
- Width rule: all shifts are logical on an XLEN vector; ASR uses the signed cast. No truncation of intermediate results.

Decomposition:
- Package operand2_pkg:
  - shift_kind_e {SH_LSL, SH_LSR, SH_ASR, SH_ROR}
  - op_mode_e {OP_MEM, OP_IMM_ROT, OP_IMM_SH, OP_REG_SH}
  - decoded-request struct (mode, kind, amt[7:0], is_rrx, rm, carry_in)
  - localparam ROT_FIELD_LSB = 8
- Sub-module barrel_shift_core: purely combinational. Takes (kind, amt, is_rrx, rm, carry_in) and returns (val2, carry). Instantiated once in the last stage.

Test Plan:
- imm=1, shift_operand=12'h4FF, carry_in=0 -> val2=32'hFF000000, shifter_carry=1, out_valid exactly PIPE_STAGES cycles after accept.
- Immediate LSR #0 (shift_operand=12'h020), rm=32'h80000001 -> val2=0, carry=1. ROR #0 (12'h060) with carry_in=1, rm=32'h00000003 -> val2=32'h80000001, carry=1.
- reg_shift=1, LSL, rm=32'h00000001, rs_val=32 -> val2=0, carry=1. rs_val=33 -> val2=0, carry=0. rs_val=0, carry_in=1 -> val2=1, carry=1.
- reg_shift=1, ROR, rm=32'h80000000, rs_val=64 -> val2=32'h80000000, carry=1. ASR, rm=32'h80000000, rs_val=200 -> val2=32'hFFFFFFFF, carry=1.
- Back-to-back stream of 8 requests with out_ready toggling 1,0,0,1: results arrive in order, none lost or duplicated, val2 stable while stalled, in_ready deasserts when full.
- flush asserted with 2 entries in flight (PIPE_STAGES=2) -> out_valid=0 next cycle. rst_n pulsed low mid-stream -> all outputs 0 immediately, asynchronously.
